// File: rtl/alu_pkg.sv
// Shared types for the two-port ALU arbiter.
// Opcode and FSM encodings plus the latched request bundle.
package alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_NAND = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    alu_op_t          op;
    logic             id;
  } alu_req_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 4-bit ALU; every result truncated to WIDTH bits.
// Divide by zero returns DIV0_VAL instead of an undefined quotient.
module alu_core
  import alu_pkg::*;
#(
  parameter int              WIDTH    = ALU_W,
  parameter logic [WIDTH-1:0] DIV0_VAL = 4'hF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (alu_op_t'(sel))
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_DIV:  y = (b == '0) ? DIV0_VAL : a / b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-port front end for one shared alu_core.
// Optional divide-by-zero flag on rsp_err when ALU_ARB_ERR_EN is defined.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int               WIDTH    = ALU_W,
  parameter logic [WIDTH-1:0] DIV0_VAL = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_id
`ifdef ALU_ARB_ERR_EN
  ,
  output logic             rsp_err
`endif
);

  arb_state_t       state_q, state_d;
  alu_req_t         req_q, req_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] alu_y;
  logic             gnt;
  logic             idle;
`ifdef ALU_ARB_ERR_EN
  logic             err_q, err_d;
`endif

  alu_core #(
    .WIDTH    (WIDTH),
    .DIV0_VAL (DIV0_VAL)
  ) u_core (
    .a   (req_q.a),
    .b   (req_q.b),
    .sel (req_q.op),
    .y   (alu_y)
  );

  // On contention the port not granted last wins; otherwise the lone valid.
  always_comb begin
    idle       = (state_q == IDLE);
    gnt        = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    req0_ready = idle & req0_valid & ~gnt;
    req1_ready = idle & req1_valid & gnt;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    last_d  = last_q;
    y_d     = y_q;
`ifdef ALU_ARB_ERR_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0_ready | req1_ready) begin
          req_d.a  = gnt ? req1_a : req0_a;
          req_d.b  = gnt ? req1_b : req0_b;
          req_d.op = alu_op_t'(gnt ? req1_sel : req0_sel);
          req_d.id = gnt;
          last_d   = gnt;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        y_d     = alu_y;
`ifdef ALU_ARB_ERR_EN
        err_d   = (req_q.op == OP_DIV) && (req_q.b == '0);
`endif
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      last_q  <= 1'b1;
      y_q     <= '0;
`ifdef ALU_ARB_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      last_q  <= last_d;
      y_q     <= y_d;
`ifdef ALU_ARB_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_y     = y_q;
  assign rsp_id    = req_q.id;
`ifdef ALU_ARB_ERR_EN
  assign rsp_err   = err_q & rsp_valid;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus handshake sequences.
// rsp_err is only compared when ALU_ARB_ERR_EN is defined.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_sel = '0, req1_sel = '0;
  logic       rsp_valid, rsp_id;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_y;
  logic       rsp_err_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_y      (rsp_y),
    .rsp_id     (rsp_id)
`ifdef ALU_ARB_ERR_EN
    ,
    .rsp_err    (rsp_err_w)
`endif
  );

`ifndef ALU_ARB_ERR_EN
  assign rsp_err_w = 1'b0;
`endif

  typedef struct {
    bit         p;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [3:0] y;
    logic       err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (2) step;
    rst_n = 1'b1;
  endtask

  task automatic drive(input bit p, input logic [3:0] a,
                       input logic [3:0] b, input logic [2:0] sel);
    if (p) begin
      req1_a = a; req1_b = b; req1_sel = sel; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_sel = sel; req0_valid = 1'b1;
    end
  endtask

  task automatic run_op(input string name, input bit p,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] sel, input logic [3:0] ey,
                        input logic eerr);
    int   n;
    logic rdy;
    drive(p, a, b, sel);
    #1;
    n   = 0;
    rdy = p ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      step;
      n++;
      rdy = p ? req1_ready : req0_ready;
    end
    chk({name, " ready"}, {7'd0, rdy}, 8'd1);
    step;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      step;
      n++;
    end
    chk({name, " valid"}, {7'd0, rsp_valid}, 8'd1);
    chk({name, " y"}, {4'd0, rsp_y}, {4'd0, ey});
    chk({name, " id"}, {7'd0, rsp_id}, {7'd0, p});
`ifdef ALU_ARB_ERR_EN
    chk({name, " err"}, {7'd0, rsp_err_w}, {7'd0, eerr});
`else
    if (eerr && rsp_err_w) $display("note: %s err set", name);
`endif
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         g[$];
    logic [4:0] r[$];

    vecs[0] = '{1'b0, 4'hA, 4'h6, 3'b100, 4'h2, 1'b0};
    vecs[1] = '{1'b1, 4'hA, 4'h6, 3'b101, 4'hE, 1'b0};
    vecs[2] = '{1'b0, 4'hA, 4'h6, 3'b110, 4'hC, 1'b0};
    vecs[3] = '{1'b1, 4'hA, 4'h6, 3'b111, 4'hD, 1'b0};
    vecs[4] = '{1'b0, 4'h2, 4'h5, 3'b001, 4'hD, 1'b0};
    vecs[5] = '{1'b1, 4'h3, 4'h5, 3'b000, 4'h8, 1'b0};
    vecs[6] = '{1'b0, 4'hC, 4'h0, 3'b011, 4'hF, 1'b1};
    vecs[7] = '{1'b1, 4'hC, 4'h4, 3'b011, 4'h3, 1'b0};
    vecs[8] = '{1'b0, 4'hF, 4'hF, 3'b010, 4'h1, 1'b0};

    // Reset state and first-op latency
    do_reset;
    chk("rst valid", {7'd0, rsp_valid}, 8'd0);
    chk("rst y", {4'd0, rsp_y}, 8'd0);
    chk("rst id", {7'd0, rsp_id}, 8'd0);
`ifdef ALU_ARB_ERR_EN
    chk("rst err", {7'd0, rsp_err_w}, 8'd0);
`endif
    drive(1'b0, 4'h3, 4'h5, 3'b000);
    #1;
    chk("t1 ready0", {7'd0, req0_ready}, 8'd1);
    chk("t1 ready1", {7'd0, req1_ready}, 8'd0);
    step;
    chk("t1 exec ready0", {7'd0, req0_ready}, 8'd0);
    chk("t1 exec valid", {7'd0, rsp_valid}, 8'd0);
    req0_valid = 1'b0;
    step;
    chk("t1 valid", {7'd0, rsp_valid}, 8'd1);
    chk("t1 y", {4'd0, rsp_y}, 8'h08);
    chk("t1 id", {7'd0, rsp_id}, 8'd0);
    step;
    chk("t1 done", {7'd0, rsp_valid}, 8'd0);

    // Table of single-port operations
    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].p, vecs[i].a, vecs[i].b,
             vecs[i].sel, vecs[i].y, vecs[i].err);
    end

    // Continuous contention from both ports
    do_reset;
    drive(1'b0, 4'h9, 4'h3, 3'b001);
    drive(1'b1, 4'h7, 4'h6, 3'b010);
    #1;
    for (int c = 0; c < 40 && r.size() < 4; c++) begin
      chk("onehot ready", {7'd0, req0_ready & req1_ready}, 8'd0);
      if (req0_ready) g.push_back(0);
      if (req1_ready) g.push_back(1);
      if (rsp_valid) r.push_back({rsp_id, rsp_y});
      step;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("cont rsp count", 8'(r.size()), 8'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cont grant%0d", i),
          (i < g.size()) ? 8'(g[i]) : 8'hFF, 8'(i % 2));
      chk($sformatf("cont rsp%0d", i),
          (i < r.size()) ? {3'd0, r[i]} : 8'hFF,
          (i % 2) ? 8'h1A : 8'h06);
    end
    step;
    step;

    // Backpressure with port 1 waiting
    do_reset;
    drive(1'b0, 4'h1, 4'h1, 3'b000);
    #1;
    chk("bp ready0", {7'd0, req0_ready}, 8'd1);
    step;
    req0_valid = 1'b0;
    rsp_ready  = 1'b0;
    step;
    drive(1'b1, 4'h2, 4'h3, 3'b000);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp valid%0d", i), {7'd0, rsp_valid}, 8'd1);
      chk($sformatf("bp y%0d", i), {4'd0, rsp_y}, 8'h02);
      chk($sformatf("bp id%0d", i), {7'd0, rsp_id}, 8'd0);
      chk($sformatf("bp ready1_%0d", i), {7'd0, req1_ready}, 8'd0);
      step;
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp ready1 resp", {7'd0, req1_ready}, 8'd0);
    step;
    chk("bp ready1 idle", {7'd0, req1_ready}, 8'd1);
    chk("bp valid low", {7'd0, rsp_valid}, 8'd0);
    step;
    req1_valid = 1'b0;
    step;
    chk("bp2 valid", {7'd0, rsp_valid}, 8'd1);
    chk("bp2 y", {4'd0, rsp_y}, 8'h05);
    chk("bp2 id", {7'd0, rsp_id}, 8'd1);
    step;

    // Reset during EXEC discards the op
    do_reset;
    drive(1'b0, 4'h5, 4'h5, 3'b000);
    #1;
    step;
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    #1;
    chk("rx valid in rst", {7'd0, rsp_valid}, 8'd0);
    step;
    step;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rx valid%0d", i), {7'd0, rsp_valid}, 8'd0);
      chk($sformatf("rx y%0d", i), {4'd0, rsp_y}, 8'd0);
      step;
    end
    req1_valid = 1'b1;
    #1;
    chk("rx idle ready1", {7'd0, req1_ready}, 8'd1);
    req1_valid = 1'b0;
    step;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 4-bit ALU. Accepts operation requests on two valid/ready ports, grants one at a time round-robin, and drives the operands through one `alu_core` instance. It registers the result and returns it on a single valid/ready response port tagged with the requester ID. It sits between the two command sources and the ALU datapath.

## Interface
- `WIDTH`, 4, operand/result width; fixed at 4 for this revision.
- `DIV0_VAL`, 4'hF, result returned for division (`sel`=3'b011) with `b`=0.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req0_valid`  in  1  port 0 request valid.
- `req0_ready`  out  1  port 0 request accepted this cycle when high with valid.
- `req0_a`, `req0_b`  in  4 each  port 0 operands.
- `req0_sel`  in  3  port 0 opcode.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sel`: same as port 0, for port 1.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_y`  out  4  result.
- `rsp_id`  out  1  requester that issued the op (0/1).
- `rsp_err`  out  1  divide-by-zero flag; present only with `ALU_ARB_ERR_EN`.

## Operation
- Opcodes: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 nand.
- All results are truncated to the low 4 bits: add and sub are modulo 16, mul keeps the low nibble, div is an unsigned quotient.
- FSM states:
  - IDLE: arbitrate. On a handshake, latch a/b/sel/id and go to EXEC.
  - EXEC: one cycle. Capture `alu_core` output into `rsp_y`, then go to RESP.
  - RESP: hold `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- Arbitration (IDLE only):
  - If exactly one port is valid, grant it.
  - If both are valid, grant the port not granted last.
  - The `last_grant` register updates on each accept.
- `reqN_ready` is combinational: IDLE and grant==N. It is never high outside IDLE, and never high on both ports at once.
- Requesters must hold valid and payload stable until accepted. A requester never sees ready without having asserted valid.
- Div with b=0 yields `DIV0_VAL`.
- Reset asserted mid-operation: FSM goes to IDLE, the in-flight op is discarded, and no response is produced.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_y`=0, `rsp_id`=0, `rsp_err`=0.
  - FSM=IDLE, `last_grant`=1, so port 0 wins the first contention.
  - `req0_ready`/`req1_ready` follow IDLE after reset: a granted valid port sees ready=1.
- Latency:
  - Accept at edge k.
  - EXEC during cycle k+1.
  - `rsp_valid`=1 from edge k+2.
  - Minimum 3 cycles per op: accept, EXEC, RESP with immediate `rsp_ready`. The next accept is possible in the cycle after the RESP handshake.
- `rsp_y`, `rsp_id` and `rsp_err` are stable while `rsp_valid`=1 and `rsp_ready`=0. Backpressure is unbounded.
- A new request arriving during EXEC or RESP waits. Arbitration uses the valid inputs in the IDLE cycle only.

## Configuration
- `ALU_ARB_ERR_EN` defined:
  - `rsp_err` port exists.
  - It is set to 1 in RESP when the op was div with b=0, otherwise 0.
  - `rsp_y` still returns `DIV0_VAL`.
- Not defined:
  - No `rsp_err` port and no error logic.
  - Div by zero silently returns `DIV0_VAL`.

## Structure
- Package `alu_pkg`:
  - `alu_op_t` enum for the eight opcodes.
  - `arb_state_t` enum (IDLE, EXEC, RESP).
  - `ALU_W`=4 constant.
- Sub-module `alu_core`: the combinational ALU with inputs a, b, sel and output y, implementing the opcode table above and the `DIV0_VAL` divide-by-zero rule. It is instantiated once in `alu_arbiter`.

## Test plan
- Reset, then port 0 requests a=4'h3, b=4'h5, sel=000, with `rsp_ready`=1 → `req0_ready`=1 on the accept cycle; `rsp_valid`=1 two edges later with `rsp_y`=4'h8, `rsp_id`=0.
- Both ports valid continuously:
  - port 0: a=9, b=3, sel=001;
  - port 1: a=7, b=6, sel=010.
  → Grants alternate 0,1,0,1; responses alternate `rsp_y`=4'h6 (id 0) and 4'hA (42 mod 16, id 1). Ready is never high on both ports.
- Div a=4'hC, b=0 → `rsp_y`=4'hF; with `ALU_ARB_ERR_EN`, `rsp_err`=1. The next op, a=4'hC, b=4'h4 div, gives `rsp_y`=3, `rsp_err`=0.
- Hold `rsp_ready`=0 for 5 cycles during RESP with port 1 valid → `rsp_valid`, `rsp_y` and `rsp_id` stay stable; `req1_ready`=0 throughout. Port 1 is accepted in the cycle after `rsp_ready`=1.
- Assert `rst_n`=0 during EXEC → `rsp_valid` stays 0 and the FSM is in IDLE after release; the discarded op produces no response.
- Logic ops with a=4'hA, b=4'h6 → and 4'h2, or 4'hE, xor 4'hC, nand 4'hD; sub a=2, b=5 → 4'hD.
